pipe_stage_skid: RTL
====================

// Module: pipe_stage_skid
// PURPOSE
//  Generalised pipeline-stage register with valid/ready handshake and 2-entry skid buffer.
//  Replaces fixed stall-only stage registers (e.g. MEM->WB) between any two CPU pipeline stages.
//  Carries a data bus, a control bus and a destination-register address.
//  Supports back-pressure, stall, flush and bubble zeroing at full throughput.
// PARAMETERS
//  DATA_W  64  payload data width (e.g. ALU result + memory read data, 2x32)
//  CTRL_W  2   control-bit width (e.g. RegWrite, MemToReg)
//  RD_W    5   destination register address width
// PORTS
//  clk_i     in   1       clock, rising edge
//  rst_i     in   1       asynchronous reset, active-high
//  flush_i   in   1       synchronous flush, drops all held entries
//  stall_i   in   1       freeze: no accept, no release this cycle
//  valid_i   in   1       upstream entry valid
//  ready_o   out  1       stage can accept this cycle
//  data_i    in   DATA_W  upstream data
//  ctrl_i    in   CTRL_W  upstream control bits
//  rd_i      in   RD_W    upstream destination register
//  valid_o   out  1       downstream entry valid
//  ready_i   in   1       downstream accepts this cycle
//  data_o    out  DATA_W  head data, zero when valid_o=0
//  ctrl_o    out  CTRL_W  head control, zero when valid_o=0
//  rd_o      out  RD_W    head destination, zero when valid_o=0
//  bp_cnt_o  out  32      back-pressure cycle count (PIPE_STAGE_PERF_EN only)
// BEHAVIOUR
//  - Storage: head slot H (drives outputs) and skid slot S, each {vld,data,ctrl,rd}.
//  - rst_i high: all slot vld, data, ctrl, rd and bp_cnt_o cleared immediately; all outputs 0.
//  - accept = valid_i & ready_o.  release = valid_o & ready_i.
//  - ready_o = ~S.vld & ~stall_i & ~flush_i (combinational; no dependence on ready_i).
//  - valid_o = H.vld & ~stall_i & ~flush_i.
//  - data_o/ctrl_o/rd_o = H fields when valid_o, else all-zero bubble.
//  - Latency: empty stage, accept in cycle N -> valid_o high in cycle N+1.
//  - Per clock, priority: flush_i > stall_i > normal.
//      flush_i: H.vld=S.vld=0; the input is dropped.
//      stall_i: all state held.
//      normal, (release, accept) ->
//        (0,0) hold;
//        (1,0) H<=S, S.vld<=0;
//        (0,1) H empty: H<=in, else S<=in;
//        (1,1) S empty: H<=in, else H<=S and S<=in.
//  - Full throughput: continuous valid_i with ready_i=1 gives one transfer per cycle, S stays empty.
//  - Back-pressure: ready_i=0 while H full -> one more entry lands in S, then ready_o=0.
//  - Ordering: strictly FIFO; no entry dropped or duplicated except by flush_i.
//  - Reset mid-transfer discards both slots; the first post-reset accept is the new head.
// CONFIGURATION
//  PIPE_STAGE_PERF_EN defined:
//    bp_cnt_o present; increments each cycle H.vld & ~ready_i & ~stall_i;
//    saturates at 32'hFFFF_FFFF; cleared by rst_i only, not by flush_i.
//  PIPE_STAGE_PERF_EN undefined: port and counter logic absent; behaviour otherwise identical.
// STRUCTURE
//  - Package pipe_pkg: default widths (DATA_W_DEF, CTRL_W_DEF, RD_W_DEF), CTRL bit indices
//    (CTRL_REGWRITE=0, CTRL_MEMTOREG=1), stage_entry_t typedef {vld,data,ctrl,rd}.
//  - Sub-module pipe_slot: one clear/hold/load register of stage_entry_t with async reset;
//    instantiated twice (H, S). Top level holds the control logic, muxing and optional counter.
// TESTING
//  1 Reset: rst_i=1 mid-stream with H,S full -> valid_o=0, ready_o=1, outputs 0 same cycle.
//  2 Streaming: 8 entries data=1..8, ready_i=1 -> valid_o from cycle 1, outputs 1..8 in order, S never valid.
//  3 Back-pressure: ready_i=0 after entry 1 -> entry 2 in S, ready_o=0;
//    ready_i=1 -> outputs 1,2,3... with no loss.
//  4 Stall: stall_i=1 for 3 cycles with H=5, S=6 -> valid_o=0, ready_o=0, state held;
//    release -> 5 then 6.
//  5 Flush vs stall: flush_i=1 & stall_i=1 & valid_i=1 with H,S full -> next cycle both empty,
//    input dropped, outputs zero.
//  6 PERF_EN: H valid, ready_i=0 for 10 cycles, 2 of them stalled -> bp_cnt_o=8; flush leaves it 8.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage skid register.
// Default widths, control-bit positions and the stage entry record.
package pipe_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int CTRL_W_DEF = 2;
  localparam int RD_W_DEF   = 5;

  // Bit positions inside the control bus
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;

  // One stage entry at the default widths
  typedef struct packed {
    logic                  vld;
    logic [DATA_W_DEF-1:0] data;
    logic [CTRL_W_DEF-1:0] ctrl;
    logic [RD_W_DEF-1:0]   rd;
  } stage_entry_t;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the skid stage: clear / hold / load register.
// Clear has priority over load; asynchronous active-high reset.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter type entry_t = stage_entry_t
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   i_clr,
  input  logic   i_load,
  input  entry_t i_d,
  output entry_t o_q
);

  entry_t r_q;

  // Slot register: reset/clear empties the slot, load captures a new entry
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake and a 2-entry skid
// buffer (head slot H drives the outputs, skid slot S absorbs one entry
// under back-pressure). Priority per clock: flush > stall > normal.
// Optional back-pressure counter enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int RD_W   = RD_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [RD_W-1:0]   rd_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [RD_W-1:0]   rd_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       bp_cnt_o
`endif
);

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
    logic [RD_W-1:0]   rd;
  } entry_t;

  entry_t w_h;
  entry_t w_s;
  entry_t w_in;
  entry_t w_h_d;
  entry_t w_s_d;
  logic   w_h_clr;
  logic   w_h_load;
  logic   w_s_clr;
  logic   w_s_load;
  logic   w_accept;
  logic   w_release;

  assign w_in = '{vld: 1'b1, data: data_i, ctrl: ctrl_i, rd: rd_i};

  // Handshake: ready never looks at ready_i, so there is no comb path through the stage
  assign ready_o   = ~w_s.vld & ~stall_i & ~flush_i;
  assign valid_o   = w_h.vld & ~stall_i & ~flush_i;
  assign w_accept  = valid_i & ready_o;
  assign w_release = valid_o & ready_i;

  // Bubble zeroing: payload is forced to zero whenever no entry is offered
  assign data_o = valid_o ? w_h.data : {DATA_W{1'b0}};
  assign ctrl_o = valid_o ? w_h.ctrl : {CTRL_W{1'b0}};
  assign rd_o   = valid_o ? w_h.rd   : {RD_W{1'b0}};

  // Slot update control: flush empties both, stall holds, otherwise move by (release, accept)
  always_comb begin
    w_h_clr  = 1'b0;
    w_h_load = 1'b0;
    w_h_d    = w_h;
    w_s_clr  = 1'b0;
    w_s_load = 1'b0;
    w_s_d    = w_s;
    if (flush_i) begin
      w_h_clr = 1'b1;
      w_s_clr = 1'b1;
    end else if (stall_i) begin
      w_h_load = 1'b0;
    end else begin
      case ({w_release, w_accept})
        2'b01: begin
          if (!w_h.vld) begin
            w_h_load = 1'b1;
            w_h_d    = w_in;
          end else begin
            w_s_load = 1'b1;
            w_s_d    = w_in;
          end
        end
        2'b10: begin
          // Skid entry (possibly empty) moves up to head
          w_h_load = 1'b1;
          w_h_d    = w_s;
          w_s_clr  = 1'b1;
        end
        2'b11: begin
          if (!w_s.vld) begin
            w_h_load = 1'b1;
            w_h_d    = w_in;
          end else begin
            w_h_load = 1'b1;
            w_h_d    = w_s;
            w_s_load = 1'b1;
            w_s_d    = w_in;
          end
        end
        default: begin
          w_h_load = 1'b0;
        end
      endcase
    end
  end

  pipe_slot #(.entry_t(entry_t)) u_head (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_clr  (w_h_clr),
    .i_load (w_h_load),
    .i_d    (w_h_d),
    .o_q    (w_h)
  );

  pipe_slot #(.entry_t(entry_t)) u_skid (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_clr  (w_s_clr),
    .i_load (w_s_load),
    .i_d    (w_s_d),
    .o_q    (w_s)
  );

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] r_bp_cnt;

  // Back-pressure counter: head held by downstream while not stalled; saturating, flush-immune
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bp_cnt <= 32'd0;
    end else if (w_h.vld && !ready_i && !stall_i && (r_bp_cnt != 32'hFFFF_FFFF)) begin
      r_bp_cnt <= r_bp_cnt + 32'd1;
    end else begin
      r_bp_cnt <= r_bp_cnt;
    end
  end

  assign bp_cnt_o = r_bp_cnt;
`endif

endmodule
